// File: rtl/ex_stage_pkg.sv
// Shared widths and opcode encoding for the 8-bit execute stage.
package ex_stage_pkg;
  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LI  = 2'b10,
    OP_JMP = 2'b11
  } opcode_e;

  // ID/EX slot. A flushed or reset slot has valid=0 and every other field zero.
  typedef struct packed {
    logic              valid;
    opcode_e           op;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rr1;
    logic [REG_AW-1:0] rr2;
    logic [REG_AW-1:0] wr;
    logic              ws;
  } idex_t;
endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 8-bit ALU: ADD/SUB with carry (borrow on SUB), LI pass-through, JMP yields 0.
module alu8
  import ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [OP_W-1:0]   opcode_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum      = {1'b0, op1_i} + {1'b0, op2_i};
    // The ninth bit of a zero-extended subtraction is set exactly when op1 < op2.
    diff     = {1'b0, op1_i} - {1'b0, op2_i};
    result_o = '0;
    carry_o  = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        result_o = diff[DATA_W-1:0];
        carry_o  = diff[DATA_W];
      end
      OP_LI:   result_o = imm_i;
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding from EX/WB, ALU and condition flags.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [OP_W-1:0]   opcodeIn,
  input  logic [DATA_W-1:0] ReadData1In,
  input  logic [DATA_W-1:0] ReadData2In,
  input  logic [REG_AW-1:0] ReadReg1In,
  input  logic [REG_AW-1:0] ReadReg2In,
  input  logic [DATA_W-1:0] ImmIn,
  input  logic [REG_AW-1:0] WriteRegisterIn,
  input  logic              WriteSignalIn,
  input  logic [DATA_W-1:0] FwdDataIn,
  input  logic [REG_AW-1:0] FwdRegIn,
  input  logic              FwdWriteIn,
  output logic [OP_W-1:0]   opcodeOut,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic              WriteSignalOut,
  output logic [REG_AW-1:0] WriteRegisterOut,
  output logic              ZeroFlag,
  output logic              CarryFlag
);
  idex_t             idex_q, idex_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] op1, op2;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_zero;
  logic              retire_arith;

  // Register 0 is an ordinary register, so it is forwarded like any other.
  assign op1 = (FwdWriteIn && (FwdRegIn == idex_q.rr1)) ? FwdDataIn : idex_q.rd1;
  assign op2 = (FwdWriteIn && (FwdRegIn == idex_q.rr2)) ? FwdDataIn : idex_q.rd2;

  alu8 u_alu (
    .op1_i    (op1),
    .op2_i    (op2),
    .imm_i    (idex_q.imm),
    .opcode_i (idex_q.op),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  assign retire_arith = !stall_in && idex_q.valid &&
                        ((idex_q.op == OP_ADD) || (idex_q.op == OP_SUB));

  always_comb begin
    idex_d  = idex_q;
    zero_d  = retire_arith ? alu_zero  : zero_q;
    carry_d = retire_arith ? alu_carry : carry_q;
    if (!stall_in) begin
      if (flush_in) begin
        idex_d = '0;
      end else begin
        idex_d.valid = 1'b1;
        idex_d.op    = opcode_e'(opcodeIn);
        idex_d.rd1   = ReadData1In;
        idex_d.rd2   = ReadData2In;
        idex_d.imm   = ImmIn;
        idex_d.rr1   = ReadReg1In;
        idex_d.rr2   = ReadReg2In;
        idex_d.wr    = WriteRegisterIn;
        idex_d.ws    = WriteSignalIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      idex_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      idex_q  <= idex_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // A stalled cycle presents a bubble downstream while the slot itself is held.
  assign opcodeOut        = stall_in ? {OP_W{1'b0}} : idex_q.op;
  assign WriteSignalOut   = !stall_in && idex_q.ws && (idex_q.op != OP_JMP);
  assign WriteRegisterOut = idex_q.wr;
  assign WriteDataOut     = idex_q.valid ? alu_result : '0;
  assign ZeroFlag         = zero_q;
  assign CarryFlag        = carry_q;
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 8-bit, 8-register pipeline. It sits directly upstream of the EX/WB pipeline register and drives that register's inputs.
- Contains the ID/EX pipeline register, an 8-bit ALU, the forwarding mux fed from EX/WB outputs, and the condition-flag register.
- Result, destination register, write enable and opcode are presented combinationally from registered state, so EX/WB captures them on the next rising edge.

Parameters:
DATA_W, 8, datapath / register width
REG_AW, 3, register address width (8 registers)
OP_W, 2, opcode width

Ports:
clk  in  1  pipeline clock, rising edge
Reset  in  1  synchronous, active-high reset
stall_in  in  1  hold ID/EX contents; emit bubble downstream
flush_in  in  1  replace the instruction being captured with a bubble
opcodeIn  in  OP_W  decoded opcode from ID
ReadData1In  in  DATA_W  register-file read data, source 1
ReadData2In  in  DATA_W  register-file read data, source 2
ReadReg1In  in  REG_AW  source-1 address
ReadReg2In  in  REG_AW  source-2 address
ImmIn  in  DATA_W  sign-extended immediate
WriteRegisterIn  in  REG_AW  destination address
WriteSignalIn  in  1  destination write enable
FwdDataIn  in  DATA_W  EX/WB WriteDataOut
FwdRegIn  in  REG_AW  EX/WB WriteRegisterOut
FwdWriteIn  in  1  EX/WB WriteSignalOut
opcodeOut  out  OP_W  to EX/WB opcodeIn
WriteDataOut  out  DATA_W  ALU result, to EX/WB WriteDataIn
WriteSignalOut  out  1  to EX/WB WriteSignalIn
WriteRegisterOut  out  REG_AW  to EX/WB WriteRegisterIn
ZeroFlag  out  1  registered: last ADD/SUB result == 0
CarryFlag  out  1  registered: ADD carry-out / SUB borrow

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high; all state is updated only on the rising edge of clk.
- Priority at each rising edge: Reset > stall_in > flush_in > normal load.
- Reset: ID/EX register cleared (opcode 00, data 0, addresses 0, write enable 0); ZeroFlag=0, CarryFlag=0. Resulting outputs are all 0.
- Reset asserted mid-operation discards the in-flight instruction with no write.
- Normal load: the ID/EX register captures all ID inputs.
- Flush (stall_in=0): the register captures a bubble, i.e. opcode 00 with write enable 0; all other fields 0.
- Stall: ID/EX holds its contents, flags hold, and outputs are forced to a bubble (WriteSignalOut=0, opcodeOut=00). The instruction re-presents when the stall is released.
- Stall and flush asserted together: stall wins; the flush is not remembered.
- Forwarding, evaluated combinationally per operand: op = FwdDataIn when FwdWriteIn=1 and FwdRegIn==ReadRegN (registered); otherwise op = registered ReadDataN. Register 0 is an ordinary register and is forwarded.
- ALU, by registered opcode:
  - 00 ADD: op1+op2, mod 256; carry = bit 8.
  - 01 SUB: op1-op2, mod 256; carry = borrow (op1<op2 unsigned).
  - 10 LI: result = ImmIn; write enabled.
  - 11 JMP: result = 0; WriteSignalOut forced 0 regardless of the registered enable.
- WriteSignalOut otherwise equals the registered WriteSignalIn.
- Latency: ID inputs captured at edge N appear at the outputs after edge N, are captured by EX/WB at edge N+1, and are forwardable during cycle N+1.
- Flags update at the edge that retires an ADD/SUB from EX (stall_in=0, not a bubble); they hold otherwise. LI and JMP do not touch flags.
- Overflow wraps silently; no exception.

Decomposition:
- Shared package: opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_LI=2'b10, OP_JMP=2'b11; DATA_W/REG_AW/OP_W defaults.
- One natural sub-module, alu8: combinational, (op1, op2, imm, opcode) -> (result, carry, zero).
- Forwarding mux and pipeline register stay in ex_stage.

Test Plan:
- Reset held 2 cycles with all inputs nonzero -> every output 0, ZeroFlag=0, CarryFlag=0.
- ADD with ReadData1In=8'hF0, ReadData2In=8'h20, rd=3, WriteSignalIn=1 -> after the next edge WriteDataOut=8'h10, WriteRegisterOut=3, WriteSignalOut=1; one edge later CarryFlag=1, ZeroFlag=0.
- SUB with 5-5 -> WriteDataOut=0, then ZeroFlag=1, CarryFlag=0. SUB with 3-5 -> WriteDataOut=8'hFE, CarryFlag=1.
- Forwarding: EX reads reg 2 (stale ReadData1In=1) while FwdWriteIn=1, FwdRegIn=2, FwdDataIn=8'h40; ADD with op2=1 -> WriteDataOut=8'h41. Same stimulus with FwdWriteIn=0 -> 8'h02.
- JMP with WriteSignalIn=1 -> WriteSignalOut=0, flags unchanged. LI with ImmIn=8'hFD, rd=7 -> WriteDataOut=8'hFD, write=1.
- Stall 3 cycles on an ADD -> WriteSignalOut=0 during the stall, flags constant, ADD result appears on release. Flush + stall together -> ADD still completes. Flush alone -> bubble (WriteSignalOut=0, opcodeOut=00).
